// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
// Package  : parking_pkg
// Brief    : Shared types and constants for the parking gate front-end and
//            the parking core it feeds.
// Revision : 1.0 - initial release
// ============================================================================
package parking_pkg;

    // Field widths shared by the gate controller and the parking core
    localparam int SLOT_W    = 3;
    localparam int CODE_W    = 8;
    localparam int DIGIT_W   = 4;
    localparam int MAX_DIGIT = 9;

    // Exit passcode checked by the parking core; the gate only forwards codes
    localparam logic [CODE_W-1:0] PASSCODE = 8'd87;

    // Exit transaction states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        D1   = 3'd1,
        D0   = 3'd2,
        PRES = 3'd3,
        CLR  = 3'd4,
        DONE = 3'd5
    } gate_state_t;

    // True for a legal BCD keypad digit (0..9)
    function automatic logic digit_legal(input logic [DIGIT_W-1:0] digit);
        return digit <= DIGIT_W'(MAX_DIGIT);
    endfunction

    // Two BCD digits to a binary code; 99 max so CODE_W bits never overflow
    function automatic logic [CODE_W-1:0] bcd_to_code(
        input logic [DIGIT_W-1:0] tens,
        input logic [DIGIT_W-1:0] ones
    );
        return (CODE_W'(tens) * CODE_W'(10)) + CODE_W'(ones);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sensor_debounce
// Brief    : Two-flop synchroniser, consecutive-high counter and rising-edge
//            detector for a bouncy asynchronous loop sensor. Produces one
//            single-cycle pulse per vehicle.
// Revision : 1.0 - initial release
// ============================================================================
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_level_d;

    // Bring the raw sensor into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive high samples; the level rises on the Nth one and
    // any low sample drops both the count and the level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (!r_sync2) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
            if (r_cnt >= (CNT_MAX - CNT_ONE)) begin
                r_level <= 1'b1;
            end
        end
    end

    // Remember the previous debounced level for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= r_level;
        end
    end

    assign rise = r_level & ~r_level_d;

endmodule
`default_nettype wire

// File: rtl/parking_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : parking_gate_ctrl
// Brief    : Gate front-end for the parking core. Debounces the entry/exit
//            loop sensors, turns an entry into a car_arrive pulse (or an
//            entry_denied pulse when full), and runs the exit transaction:
//            two keypad digits -> present code/slot -> clear -> low gap.
// Revision : 1.0 - initial release
// ============================================================================
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int PRESENT_CYCLES  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               entry_sensor,
    input  logic               exit_sensor,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_digit,
    input  logic [SLOT_W-1:0]  slot_sel,
    input  logic               lot_full,
    output logic               car_arrive,
    output logic               car_exit,
    output logic [CODE_W-1:0]  exit_code,
    output logic [SLOT_W-1:0]  exit_from,
    output logic               entry_denied,
    output logic               bad_key,
    output logic               exit_timeout,
    output logic               busy
);

    // One timer serves both the digit timeout and the presentation hold
    localparam int TMR_MAX = (TIMEOUT_CYCLES > PRESENT_CYCLES) ? TIMEOUT_CYCLES
                                                                : PRESENT_CYCLES;
    localparam int               TMR_W     = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] PRES_LAST = TMR_W'(PRESENT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_SAT   = TMR_W'(TMR_MAX);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

    logic               w_entry_rise;
    logic               w_exit_rise;
    logic               w_digit_ok;

    logic               r_car_arrive;
    logic               r_entry_denied;

    gate_state_t        r_state;
    gate_state_t        w_state_nxt;
    logic [TMR_W-1:0]   r_timer;

    logic               w_latch_d1;
    logic               w_latch_d0;
    logic [DIGIT_W-1:0] r_d1;
    logic [CODE_W-1:0]  r_code;
    logic [SLOT_W-1:0]  r_slot;

    sensor_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_entry_debounce (
        .clk  (clk),
        .rst  (rst),
        .raw  (entry_sensor),
        .rise (w_entry_rise)
    );

    sensor_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_exit_debounce (
        .clk  (clk),
        .rst  (rst),
        .raw  (exit_sensor),
        .rise (w_exit_rise)
    );

    assign w_digit_ok = digit_legal(key_digit);

    // Entry path: independent of the exit FSM, one registered pulse per car
    always_ff @(posedge clk) begin
        if (rst) begin
            r_car_arrive   <= 1'b0;
            r_entry_denied <= 1'b0;
        end else begin
            r_car_arrive   <= w_entry_rise & ~lot_full;
            r_entry_denied <= w_entry_rise &  lot_full;
        end
    end

    assign car_arrive   = r_car_arrive;
    assign entry_denied = r_entry_denied;

    // Exit FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Cycles spent in the current state; restarts on every state change
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
        end else if (w_state_nxt != r_state) begin
            r_timer <= '0;
        end else if (r_timer != TMR_SAT) begin
            r_timer <= r_timer + TMR_ONE;
        end
    end

    // Digit capture; the code is formed when the second digit arrives so
    // it is ready on the first presentation cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d1   <= '0;
            r_code <= '0;
            r_slot <= '0;
        end else begin
            if (w_latch_d1) begin
                r_d1 <= key_digit;
            end
            if (w_latch_d0) begin
                r_code <= bcd_to_code(r_d1, key_digit);
                r_slot <= slot_sel;
            end
        end
    end

    // Exit FSM next-state and outputs; a legal key beats a same-cycle timeout
    always_comb begin
        w_state_nxt  = r_state;
        w_latch_d1   = 1'b0;
        w_latch_d0   = 1'b0;
        bad_key      = 1'b0;
        exit_timeout = 1'b0;
        car_exit     = 1'b0;
        busy         = 1'b1;
        exit_code    = '0;
        exit_from    = '0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_exit_rise) begin
                    w_state_nxt = D1;
                end
            end
            D1: begin
                car_exit = 1'b1;
                if (key_valid && w_digit_ok) begin
                    w_latch_d1  = 1'b1;
                    w_state_nxt = D0;
                end else begin
                    bad_key = key_valid;
                    if (r_timer == TMO_LAST) begin
                        exit_timeout = 1'b1;
                        w_state_nxt  = IDLE;
                    end
                end
            end
            D0: begin
                car_exit = 1'b1;
                if (key_valid && w_digit_ok) begin
                    w_latch_d0  = 1'b1;
                    w_state_nxt = PRES;
                end else begin
                    bad_key = key_valid;
                    if (r_timer == TMO_LAST) begin
                        exit_timeout = 1'b1;
                        w_state_nxt  = IDLE;
                    end
                end
            end
            PRES: begin
                car_exit  = 1'b1;
                exit_code = r_code;
                exit_from = r_slot;
                if (r_timer == PRES_LAST) begin
                    w_state_nxt = CLR;
                end
            end
            CLR: begin
                car_exit    = 1'b1;
                w_state_nxt = DONE;
            end
            DONE: begin
                // car_exit low for one cycle guarantees a gap between exits
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
